// File: rtl/pc_gen_if.sv
// Fetch-address handshake and redirect request bundle between decode/execute,
// the pc generator and instruction fetch.
interface pc_gen_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned JIDX = 26;

    logic            fetchReady;
    logic            fetchValid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            takeException;
    logic            takeEret;
    logic [XLEN-1:0] epc;
    logic            takeBranch;
    logic [XLEN-1:0] branchBase;
    logic [XLEN-1:0] branchImmEx;
    logic            takeJumpImm;
    logic [XLEN-1:0] jumpBase;
    logic [JIDX-1:0] jumpImm;
    logic            takeJumpReg;
    logic [XLEN-1:0] jumpReg;
    logic            pendingValid;

    modport master (
        input  fetchReady, takeException, takeEret, epc, takeBranch, branchBase,
               branchImmEx, takeJumpImm, jumpBase, jumpImm, takeJumpReg, jumpReg,
        output fetchValid, pc, pc4, pendingValid
    );

    modport slave (
        output fetchReady, takeException, takeEret, epc, takeBranch, branchBase,
               branchImmEx, takeJumpImm, jumpBase, jumpImm, takeJumpReg, jumpReg,
        input  fetchValid, pc, pc4, pendingValid
    );
endinterface

// File: rtl/pc_gen.sv
// MIPS fetch-stage program counter: prioritised redirects with an optional
// branch-delay-slot target latch that survives fetch stalls.
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);
    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pcQ;
    logic [XLEN-1:0] pendingQ;
    logic            fetchValidQ;
    logic            pendingValidQ;

    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] pendingNext;
    logic            pendingValidNext;

    logic            fire;
    logic            ctValid;
    logic [XLEN-1:0] ctTarget;
    logic [XLEN-1:0] branchTarget;
    logic [XLEN-1:0] jumpImmTarget;
    logic [XLEN-1:0] seqPc;

    assign fire          = fetchValidQ & bus.fetchReady;
    assign seqPc         = pcQ + XLEN'(4);
    assign branchTarget  = bus.branchBase + (bus.branchImmEx << 2);
    assign jumpImmTarget = (bus.jumpBase & 32'hF000_0000) | {4'b0000, bus.jumpImm, 2'b00};
    assign ctValid       = bus.takeBranch | bus.takeJumpImm | bus.takeJumpReg;

    // Only the highest-priority control transfer supplies the target.
    always_comb begin
        ctTarget = bus.jumpReg;
        if (bus.takeBranch) begin
            ctTarget = branchTarget;
        end else if (bus.takeJumpImm) begin
            ctTarget = jumpImmTarget;
        end
    end

    // Redirect priority; a CT arriving while a target is held is dropped.
    always_comb begin
        pcNext           = pcQ;
        pendingNext      = pendingQ;
        pendingValidNext = pendingValidQ;
        if (bus.takeException) begin
            pcNext           = EXC_VECTOR;
            pendingValidNext = 1'b0;
        end else if (bus.takeEret) begin
            pcNext           = bus.epc;
            pendingValidNext = 1'b0;
        end else if (ctValid && !DELAY_SLOT) begin
            pcNext           = ctTarget;
            pendingValidNext = 1'b0;
        end else if (ctValid && !pendingValidQ) begin
            // The fetch accepted now is the delay slot, so jump straight away.
            if (fire) begin
                pcNext = ctTarget;
            end else begin
                pendingNext      = ctTarget;
                pendingValidNext = 1'b1;
            end
        end else if (ctValid) begin
            pcNext = pcQ;
        end else if (pendingValidQ && fire) begin
            pcNext           = pendingQ;
            pendingValidNext = 1'b0;
        end else if (fire) begin
            pcNext = seqPc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcQ           <= RESET_VECTOR;
            pendingQ      <= '0;
            fetchValidQ   <= 1'b0;
            pendingValidQ <= 1'b0;
        end else begin
            pcQ           <= pcNext;
            pendingQ      <= pendingNext;
            fetchValidQ   <= 1'b1;
            pendingValidQ <= pendingValidNext;
        end
    end

    assign bus.pc           = pcQ;
    assign bus.pc4          = seqPc;
    assign bus.fetchValid   = fetchValidQ;
    assign bus.pendingValid = pendingValidQ;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed table plus random redirects, both delay-slot
// configurations checked against a reference model every cycle.
module tb_pc_gen;
    typedef struct {
        logic        ready;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        br;
        logic [31:0] brBase;
        logic [31:0] brImm;
        logic        jImm;
        logic [31:0] jBase;
        logic [25:0] jIdx;
        logic        jReg;
        logic [31:0] jRegVal;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] expPc1;
        logic        expPend1;
        logic [31:0] expPc0;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        pendV;
        logic [31:0] pend;
    } m_t;

    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam logic [31:0] EV = 32'hBFC0_0380;

    logic clk;
    logic rst;
    int   nVec;
    int   nErr;
    m_t   m1;
    m_t   m0;
    vec_t tbl [18];

    pc_gen_if bus1 ();
    pc_gen_if bus0 ();

    pc_gen #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .DELAY_SLOT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    pc_gen #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t idle(input logic ready);
        in_t i;
        i.ready = ready; i.exc = 1'b0; i.eret = 1'b0; i.epc = '0;
        i.br = 1'b0; i.brBase = '0; i.brImm = '0;
        i.jImm = 1'b0; i.jBase = '0; i.jIdx = '0;
        i.jReg = 1'b0; i.jRegVal = '0;
        return i;
    endfunction

    function automatic vec_t row(input in_t i, input logic [31:0] p1,
                                 input logic d1, input logic [31:0] p0);
        vec_t v;
        v.in = i; v.expPc1 = p1; v.expPend1 = d1; v.expPc0 = p0;
        return v;
    endfunction

    function automatic m_t resetState();
        m_t s;
        s.pc = RV; s.valid = 1'b0; s.pendV = 1'b0; s.pend = '0;
        return s;
    endfunction

    // Next fetch state from the redirect rules, written as plain arithmetic.
    function automatic m_t step(input m_t s, input in_t i, input bit ds);
        m_t          n;
        logic [31:0] tgt;
        bit          ct;
        bit          fire;
        n     = s;
        fire  = s.valid && i.ready;
        ct    = i.br || i.jImm || i.jReg;
        if (i.br)        tgt = i.brBase + i.brImm * 32'd4;
        else if (i.jImm) tgt = (i.jBase & 32'hF000_0000) + {6'd0, i.jIdx} * 32'd4;
        else             tgt = i.jRegVal;
        n.valid = 1'b1;
        if (i.exc) begin
            n.pc = EV; n.pendV = 1'b0;
        end else if (i.eret) begin
            n.pc = i.epc; n.pendV = 1'b0;
        end else if (ct && !ds) begin
            n.pc = tgt; n.pendV = 1'b0;
        end else if (ct && !s.pendV) begin
            if (fire) n.pc = tgt;
            else begin n.pend = tgt; n.pendV = 1'b1; end
        end else if (ct) begin
            n.pc = s.pc;
        end else if (s.pendV && fire) begin
            n.pc = s.pend; n.pendV = 1'b0;
        end else if (fire) begin
            n.pc = s.pc + 32'd4;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t i);
        bus1.fetchReady = i.ready;   bus0.fetchReady = i.ready;
        bus1.takeException = i.exc;  bus0.takeException = i.exc;
        bus1.takeEret = i.eret;      bus0.takeEret = i.eret;
        bus1.epc = i.epc;            bus0.epc = i.epc;
        bus1.takeBranch = i.br;      bus0.takeBranch = i.br;
        bus1.branchBase = i.brBase;  bus0.branchBase = i.brBase;
        bus1.branchImmEx = i.brImm;  bus0.branchImmEx = i.brImm;
        bus1.takeJumpImm = i.jImm;   bus0.takeJumpImm = i.jImm;
        bus1.jumpBase = i.jBase;     bus0.jumpBase = i.jBase;
        bus1.jumpImm = i.jIdx;       bus0.jumpImm = i.jIdx;
        bus1.takeJumpReg = i.jReg;   bus0.takeJumpReg = i.jReg;
        bus1.jumpReg = i.jRegVal;    bus0.jumpReg = i.jRegVal;
    endtask

    task automatic checkModel();
        check("pc1",    bus1.pc, m1.pc);
        check("pc4_1",  bus1.pc4, m1.pc + 32'd4);
        check("valid1", 32'(bus1.fetchValid), 32'(m1.valid));
        check("pend1",  32'(bus1.pendingValid), 32'(m1.pendV));
        check("pc0",    bus0.pc, m0.pc);
        check("pc4_0",  bus0.pc4, m0.pc + 32'd4);
        check("valid0", 32'(bus0.fetchValid), 32'(m0.valid));
        check("pend0",  32'(bus0.pendingValid), 32'(m0.pendV));
    endtask

    // Inputs change on the falling edge; outputs are checked on the next one.
    task automatic cycle(input in_t i);
        drive(i);
        @(posedge clk);
        m1 = step(m1, i, 1'b1);
        m0 = step(m0, i, 1'b0);
        @(negedge clk);
        checkModel();
    endtask

    initial begin
        in_t v;
        nVec = 0;
        nErr = 0;

        v = idle(1'b1);
        tbl[0] = row(v, 32'hBFC00000, 1'b0, 32'hBFC00000);
        tbl[1] = row(v, 32'hBFC00004, 1'b0, 32'hBFC00004);
        tbl[2] = row(v, 32'hBFC00008, 1'b0, 32'hBFC00008);
        tbl[3] = row(v, 32'hBFC0000C, 1'b0, 32'hBFC0000C);
        tbl[4] = row(v, 32'hBFC00010, 1'b0, 32'hBFC00010);
        v = idle(1'b0); v.br = 1'b1; v.brBase = 32'hBFC0000C; v.brImm = 32'hFFFFFFFE;
        tbl[5] = row(v, 32'hBFC00010, 1'b1, 32'hBFC00004);
        v = idle(1'b0);
        tbl[6] = row(v, 32'hBFC00010, 1'b1, 32'hBFC00004);
        tbl[7] = row(v, 32'hBFC00010, 1'b1, 32'hBFC00004);
        v = idle(1'b1);
        tbl[8] = row(v, 32'hBFC00004, 1'b0, 32'hBFC00008);
        v = idle(1'b1); v.jImm = 1'b1; v.jBase = 32'hBFC00020; v.jIdx = 26'h0000040;
        tbl[9] = row(v, 32'hB0000100, 1'b0, 32'hB0000100);
        v = idle(1'b0); v.jReg = 1'b1; v.jRegVal = 32'h00400000;
        tbl[10] = row(v, 32'hB0000100, 1'b1, 32'h00400000);
        v = idle(1'b0); v.exc = 1'b1;
        tbl[11] = row(v, 32'hBFC00380, 1'b0, 32'hBFC00380);
        v = idle(1'b1);
        tbl[12] = row(v, 32'hBFC00384, 1'b0, 32'hBFC00384);
        v = idle(1'b1); v.eret = 1'b1; v.epc = 32'h80001234; v.br = 1'b1; v.brImm = 32'd4;
        tbl[13] = row(v, 32'h80001234, 1'b0, 32'h80001234);
        v = idle(1'b1);
        tbl[14] = row(v, 32'h80001238, 1'b0, 32'h80001238);
        v = idle(1'b0); v.br = 1'b1; v.brBase = 32'h80001238; v.brImm = 32'd1;
        tbl[15] = row(v, 32'h80001238, 1'b1, 32'h8000123C);
        v = idle(1'b0); v.jReg = 1'b1; v.jRegVal = 32'h12345678;
        tbl[16] = row(v, 32'h80001238, 1'b1, 32'h12345678);
        v = idle(1'b1);
        tbl[17] = row(v, 32'h8000123C, 1'b0, 32'h1234567C);

        rst = 1'b0;
        drive(idle(1'b0));
        m1 = resetState();
        m0 = resetState();
        @(negedge clk);
        checkModel();
        rst = 1'b1;

        for (int k = 0; k < 18; k++) begin
            cycle(tbl[k].in);
            check($sformatf("t%0d_pc1", k), bus1.pc, tbl[k].expPc1);
            check($sformatf("t%0d_pend1", k), 32'(bus1.pendingValid), 32'(tbl[k].expPend1));
            check($sformatf("t%0d_valid1", k), 32'(bus1.fetchValid), 32'd1);
            check($sformatf("t%0d_pc0", k), bus0.pc, tbl[k].expPc0);
        end

        // Asynchronous reset while a delayed target is held.
        v = idle(1'b0); v.jReg = 1'b1; v.jRegVal = 32'h00ABCDE0;
        cycle(v);
        check("ar_pendBefore", 32'(bus1.pendingValid), 32'd1);
        drive(idle(1'b0));
        #2 rst = 1'b0;
        #1;
        check("ar_pc1",    bus1.pc, RV);
        check("ar_valid1", 32'(bus1.fetchValid), 32'd0);
        check("ar_pend1",  32'(bus1.pendingValid), 32'd0);
        check("ar_pc0",    bus0.pc, RV);
        m1 = resetState();
        m0 = resetState();
        @(negedge clk);
        rst = 1'b1;

        // Redirect on the very first cycle out of reset is still honoured.
        v = idle(1'b1); v.eret = 1'b1; v.epc = 32'h00000100;
        cycle(v);
        check("first_eret", bus1.pc, 32'h00000100);
        cycle(idle(1'b1));
        check("held_tgt_dropped", bus1.pc, 32'h00000104);

        for (int n = 0; n < 600; n++) begin
            v = idle($urandom_range(0, 3) != 0);
            v.exc     = ($urandom_range(0, 31) == 0);
            v.eret    = ($urandom_range(0, 23) == 0);
            v.epc     = $urandom;
            v.br      = ($urandom_range(0, 7) == 0);
            v.brBase  = $urandom;
            v.brImm   = $urandom;
            v.jImm    = ($urandom_range(0, 9) == 0);
            v.jBase   = $urandom;
            v.jIdx    = 26'($urandom);
            v.jReg    = ($urandom_range(0, 9) == 0);
            v.jRegVal = $urandom;
            if (m1.pendV) begin
                v.br = 1'b0; v.jImm = 1'b0; v.jReg = 1'b0;
            end
            cycle(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter generator for the MIPS fetch stage.
- Holds the fetch address and presents it to instruction fetch through a valid/ready handshake.
- Applies redirects with a fixed priority: exception, eret, branch, jump-imm, jump-reg.
- Optionally honours the MIPS branch delay slot by latching control-transfer targets until the delay-slot fetch is accepted, so redirects survive fetch stalls.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, pc value loaded by reset.
- EXC_VECTOR, 32'hBFC0_0380, pc target on exception.
- DELAY_SLOT, 1, 1 = branch/jump targets take effect after one delay-slot fetch; 0 = immediate.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetchReady  in  1  fetch stage accepts pc this cycle.
- fetchValid  out  1  pc is a valid fetch address.
- pc  out  32  current fetch address.
- pc4  out  32  pc + 4, combinational.
- takeException  in  1  exception redirect.
- takeEret  in  1  eret redirect.
- epc  in  32  eret target.
- takeBranch  in  1  taken branch.
- branchBase  in  32  pc+4 of the branch instruction.
- branchImmEx  in  32  sign-extended branch offset in words.
- takeJumpImm  in  1  j/jal.
- jumpBase  in  32  pc+4 of the jump instruction.
- jumpImm  in  26  jump index.
- takeJumpReg  in  1  jr/jalr.
- jumpReg  in  32  register target.
- pendingValid  out  1  a delayed target is held.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_VECTOR, fetchValid=0, pendingValid=0, pending target=0.
  - First rising edge with rst=1: fetchValid<=1 and stays 1 thereafter; pc unchanged on that edge.
- fire = fetchValid & fetchReady. pc advances only on fire unless a redirect applies.
- Target arithmetic, all mod 2^32, no overflow flag:
  - branch: branchBase + (branchImmEx<<2).
  - jump-imm: {jumpBase[31:28], jumpImm, 2'b00}.
  - jump-reg: jumpReg unmodified; no alignment check.
- Control transfer (CT) = takeBranch|takeJumpImm|takeJumpReg. Only the highest-priority asserted CT is used.
- Per rising edge, first matching rule wins:
  1. takeException: pc<=EXC_VECTOR, pendingValid<=0. Regardless of fire; the in-flight fetch is dropped.
  2. takeEret: pc<=epc, pendingValid<=0.
  3. CT with DELAY_SLOT=0: pc<=target, pendingValid<=0.
  4. CT with DELAY_SLOT=1, pendingValid=0:
     - fire: current pc is the delay slot, so pc<=target directly.
     - no fire: pending<=target, pendingValid<=1, pc held.
  5. CT with pendingValid=1: request ignored; first target is retained. Decode never issues this; the bench flags it.
  6. pendingValid=1 and fire: pc<=pending, pendingValid<=0. The accepted fetch was the delay slot.
  7. fire: pc<=pc4.
  8. Otherwise: hold.
- Redirects are single-cycle pulses and are never dropped by fetchReady=0.
- Redirects with fetchValid=0 (first cycle after reset) are honoured by the same rules.
- Latency: target visible on pc one cycle after request, or one cycle after the delay-slot fire.
- Reset mid-operation: immediate return to reset values; pending target discarded.

Test Plan:
- Reset then fetchReady=1 for 3 cycles -> pc BFC00000 (valid), BFC00004, BFC00008; pendingValid=0 throughout.
- DELAY_SLOT=1, pc=BFC00010, fetchReady=0, takeBranch with branchBase=BFC0000C, branchImmEx=FFFFFFFE:
  - -> pendingValid=1, pc held at BFC00010.
  - fetchReady=1 after 3 stall cycles -> fire at BFC00010, then pc=BFC00004, pendingValid=0.
- DELAY_SLOT=1, CT with fire in same cycle, takeJumpImm with jumpBase=BFC00020, jumpImm=0000040 -> next pc=B0000100; pendingValid never set.
- pendingValid=1, takeException -> pc=BFC00380 next cycle, pendingValid=0; held target never applied.
- Simultaneous takeEret (epc=80001234) and takeBranch -> pc=80001234; branch ignored. With DELAY_SLOT=0, takeJumpReg=00400000 -> pc=00400000 next cycle.
- Assert rst=0 asynchronously mid-stall with pendingValid=1 -> pc=BFC00000, fetchValid=0, pendingValid=0 without waiting for a clock edge.
